// File: rtl/nbit_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nbit_mux : single-bit 2^SELECT_WIDTH:1 mux tree with registered copy     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module nbit_mux #(
  parameter int SELECT_WIDTH = 1
) (
  input  logic [(2**SELECT_WIDTH)-1:0] data,
  output logic                         out,
  input  logic [SELECT_WIDTH-1:0]      select,
  input  logic                         clk,
  input  logic                         reset,
  output logic                         out_q
);

  localparam int c_N     = 2**SELECT_WIDTH;
  localparam int c_NODES = 2*c_N - 1;

  // Heap-ordered tree: node i has children 2i+1 (sel=0) and 2i+2 (sel=1);
  // leaves occupy indices N-1 .. 2N-2 and hold data[0] .. data[N-1].
  logic [c_NODES-1:0] w_tree;

  genvar k;
  generate
    for (k = 0; k < c_N; k++) begin : g_leaf
      assign w_tree[c_N-1+k] = data[k];
    end
  endgenerate

  // Depth d is steered by select[SELECT_WIDTH-1-d], so the leaf level uses select[0].
  genvar d, n;
  generate
    for (d = 0; d < SELECT_WIDTH; d++) begin : g_level
      for (n = 0; n < 2**d; n++) begin : g_node
        localparam int c_IDX = (2**d) - 1 + n;
        assign w_tree[c_IDX] = select[SELECT_WIDTH-1-d] ? w_tree[2*c_IDX+2]
                                                        : w_tree[2*c_IDX+1];
      end
    end
  endgenerate

  assign out = w_tree[0];

  logic out_d;
  assign out_d = out;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nbit_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nbit_mux : directed and random checks of nbit_mux                     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_nbit_mux;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // SELECT_WIDTH=2, clocked
  logic [3:0] d2;
  logic [1:0] s2;
  logic       o2, q2;
  // SELECT_WIDTH=2, 3:1 usage with clock/reset held at X
  logic [3:0] d31;
  logic [1:0] s31;
  logic       o31, q31;
  logic       clk_x = 1'bx;
  logic       rst_x = 1'bx;
  // SELECT_WIDTH=1
  logic [1:0] d1;
  logic       s1;
  logic       o1, q1;
  // SELECT_WIDTH=5
  logic [31:0] d5;
  logic [4:0]  s5;
  logic        o5, q5;
  // SELECT_WIDTH=3, clocked, random
  logic [7:0] d3;
  logic [2:0] s3;
  logic       o3, q3;

  nbit_mux #(.SELECT_WIDTH(2)) u2  (.data(d2),  .out(o2),  .select(s2),  .clk(clk),   .reset(reset), .out_q(q2));
  nbit_mux #(.SELECT_WIDTH(2)) u31 (.data(d31), .out(o31), .select(s31), .clk(clk_x), .reset(rst_x), .out_q(q31));
  nbit_mux #(.SELECT_WIDTH(1)) u1  (.data(d1),  .out(o1),  .select(s1),  .clk(clk),   .reset(reset), .out_q(q1));
  nbit_mux #(.SELECT_WIDTH(5)) u5  (.data(d5),  .out(o5),  .select(s5),  .clk(clk),   .reset(reset), .out_q(q5));
  nbit_mux #(.SELECT_WIDTH(3)) u3  (.data(d3),  .out(o3),  .select(s3),  .clk(clk),   .reset(reset), .out_q(q3));

  int   n_cmp = 0;
  int   n_err = 0;
  logic sb[$];

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic obs);
    logic e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=%b expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    logic       r;

    d2 = '0; s2 = '0; d31 = '0; s31 = '0;
    d1 = '0; s1 = '0; d5 = '0; s5 = '0; d3 = '0; s3 = '0;

    // Combinational 4:1 with 4'b0110, no clock edge between steps
    d2 = 4'b0110;
    pat = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      s2 = 2'(s);
      #1;
      check($sformatf("comb4_sel%0d", s), o2, pat[s]);
    end

    // 3:1 usage {0, in2=0, in1=1, in0=1}, clk/reset at X
    d31 = {1'b0, 1'b0, 1'b1, 1'b1};
    pat = 4'b0011;
    for (int s = 0; s < 4; s++) begin
      s31 = 2'(s);
      #1;
      check($sformatf("mux3_sel%0d", s), o31, pat[s]);
    end

    // Walking one, SELECT_WIDTH=1
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        d1 = 2'(1) << k;
        s1 = s[0];
        #1;
        check($sformatf("walk1_k%0d_s%0d", k, s), o1, (s == k));
      end
    end

    // Walking one, SELECT_WIDTH=5
    for (int k = 0; k < 32; k++) begin
      for (int s = 0; s < 32; s++) begin
        d5 = 32'(1) << k;
        s5 = 5'(s);
        #1;
        check($sformatf("walk5_k%0d_s%0d", k, s), o5, (s == k));
      end
    end

    // Registered path: reset held for two edges
    @(negedge clk);
    reset = 1'b1;
    d2 = 4'b1000; s2 = 2'd3;
    edge_then_settle();
    @(negedge clk);
    sb.push_back(1'b0);
    edge_then_settle();
    sb_check("rst_hold_outq", q2);

    @(negedge clk);
    reset = 1'b0;
    d2 = 4'b1000; s2 = 2'd3;
    #1;
    check("sel3_out", o2, 1'b1);
    sb.push_back(1'b1);
    edge_then_settle();
    sb_check("sel3_outq", q2);

    @(negedge clk);
    s2 = 2'd0;
    #1;
    check("sel0_out_immediate", o2, 1'b0);
    check("sel0_outq_still_old", q2, 1'b1);
    sb.push_back(1'b0);
    edge_then_settle();
    sb_check("sel0_outq", q2);

    // Reset priority over data load
    @(negedge clk);
    s2 = 2'd3;
    reset = 1'b1;
    #1;
    check("prio_out_unaffected", o2, 1'b1);
    sb.push_back(1'b0);
    edge_then_settle();
    sb_check("prio_outq_reset", q2);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(1'b1);
    edge_then_settle();
    sb_check("prio_outq_release", q2);

    // Random, SELECT_WIDTH=3
    @(negedge clk);
    reset = 1'b1;
    edge_then_settle();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      d3 = 8'($urandom);
      s3 = 3'($urandom_range(7, 0));
      r  = d3[s3];
      #1;
      check($sformatf("rand_out_%0d", i), o3, r);
      sb.push_back(r);
      edge_then_settle();
      sb_check($sformatf("rand_outq_%0d", i), q3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog observed=timeout expected=completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
